// File: rtl/game_state_module.sv
// Screen sequencer for the game: READY -> PLAY -> OVER -> READY.
// The start key is synchronized and debounced. Screen changes are held in a
// pending register and only applied on a vsync falling edge, so the visible
// screen never switches mid-frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// READY | title screen, waiting for a start press
// PLAY  | game running, waiting for the stack to reach the top row
// OVER  | game-over screen, left on a press or after OVER_HOLD cycles
module game_state_module #(
    parameter int DB_CNT    = 1000000,
    parameter int OVER_HOLD = 150000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_start_n,
    input  logic over_det,
    input  logic vsync,
    output logic gameready_sig,
    output logic start_sig,
    output logic over_sig,
    output logic game_rst_n,
    output logic key_press
);

    localparam int DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int OV_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
    localparam logic [OV_W-1:0] OV_LAST = OV_W'(OVER_HOLD - 1);

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    logic            key_meta;
    logic            key_sync;
    logic            vs_meta;
    logic            vs_sync;
    logic            vs_prev;
    logic            frame_edge;

    logic [DB_W-1:0] db_cnt;
    logic            key_stable;
    logic            key_stable_d;

    state_t          state;
    state_t          pend_state;
    logic            pend_valid;
    logic [OV_W-1:0] over_cnt;

    logic            timeout;
    logic            commit;
    logic            req_valid;
    state_t          req_state;

    function automatic logic [2:0] screen_bits(input state_t s);
        logic [2:0] b;
        b = 3'b100;
        case (s)
            ST_READY: b = 3'b100;
            ST_PLAY:  b = 3'b010;
            ST_OVER:  b = 3'b001;
            default:  b = 3'b100;
        endcase
        return b;
    endfunction

    // Two-flop synchronizers for the key and vsync, plus vsync history for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            vs_meta  <= 1'b1;
            vs_sync  <= 1'b1;
            vs_prev  <= 1'b1;
        end else begin
            key_meta <= key_start_n;
            key_sync <= key_meta;
            vs_meta  <= vsync;
            vs_sync  <= vs_meta;
            vs_prev  <= vs_sync;
        end
    end

    assign frame_edge = vs_prev & ~vs_sync;

    // Debouncer: adopt the synchronized level after DB_CNT consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt     <= '0;
            key_stable <= 1'b1;
        end else if (key_sync != key_stable) begin
            if (db_cnt == DB_LAST) begin
                key_stable <= key_sync;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // One-cycle press pulse on the falling edge of the debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable_d <= 1'b1;
            key_press    <= 1'b0;
        end else begin
            key_stable_d <= key_stable;
            key_press    <= key_stable_d & ~key_stable;
        end
    end

    assign timeout = (state == ST_OVER) && (over_cnt == OV_LAST);
    assign commit  = frame_edge & pend_valid;

    // Transition request raised by the current screen
    always_comb begin
        req_valid = 1'b0;
        req_state = ST_READY;
        case (state)
            ST_READY: begin
                if (key_press) begin
                    req_valid = 1'b1;
                    req_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (over_det) begin
                    req_valid = 1'b1;
                    req_state = ST_OVER;
                end
            end
            ST_OVER: begin
                if (key_press || timeout) begin
                    req_valid = 1'b1;
                    req_state = ST_READY;
                end
            end
            default: begin
                req_valid = 1'b0;
                req_state = ST_READY;
            end
        endcase
    end

    // Screen FSM: latch one pending request, apply it on the next frame edge.
    // A request arriving on a frame edge with nothing pending is latched and
    // so waits for the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_READY;
            pend_state    <= ST_READY;
            pend_valid    <= 1'b0;
            over_cnt      <= '0;
            gameready_sig <= 1'b1;
            start_sig     <= 1'b0;
            over_sig      <= 1'b0;
            game_rst_n    <= 1'b1;
        end else begin
            game_rst_n <= 1'b1;
            if (commit) begin
                state      <= pend_state;
                pend_valid <= 1'b0;
                {gameready_sig, start_sig, over_sig} <= screen_bits(pend_state);
                if (pend_state == ST_PLAY) begin
                    game_rst_n <= 1'b0;
                end
            end else if (!pend_valid && req_valid) begin
                pend_valid <= 1'b1;
                pend_state <= req_state;
            end

            if ((state == ST_OVER) && !commit) begin
                if (over_cnt != OV_LAST) begin
                    over_cnt <= over_cnt + OV_W'(1);
                end
            end else begin
                over_cnt <= '0;
            end
        end
    end

endmodule
